data_memory_arbiter: RTL and testbench

- Two-port Avalon-MM arbiter in front of one single-port 32-bit on-chip data memory (1024 words, byte enables, 1-cycle read latency).
- Port 0 is the local processor data master; port 1 is the NoC adaptor.
- Issues at most one access per cycle to the memory, round-robin on contention, with an optional lock for atomic read-modify-write sequences and a lock timeout.

---
 rtl/data_memory_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_arbiter
//  Purpose  : Two-port Avalon-MM arbiter in front of a single-port on-chip
//             data memory. Port 0 is the local processor data master and
//             port 1 is the NoC adaptor. At most one access reaches the
//             memory per cycle. Ties are settled round-robin, and an optional
//             lock keeps the grant with one port across an atomic
//             read-modify-write sequence. A watchdog releases a lock whose
//             owner stays idle for too long.
//  Revision : 1.0  initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int READ_LATENCY = 1,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,

    // port 0: local processor data master
    input  logic              s0_chipselect,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic              s0_lock,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,

    // port 1: NoC adaptor
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic              s1_lock,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    // single-port memory
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    // one-cycle pulse after a lock was forcibly released
    output logic              lock_timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The idle counter only has to reach LOCK_TIMEOUT-1 before release.
    localparam int                c_cnt_w    = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LOCK_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Lock state encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED0 = 2'd1,
        ST_LOCKED1 = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                   r_state;
    logic                     r_rr_last;      // port accepted most recently
    logic [c_cnt_w-1:0]       r_idle_cnt;     // owner idle cycles while locked
    logic                     r_lock_timeout;
    logic [READ_LATENCY-1:0]  r_pipe_valid;   // read return pipeline: valid
    logic [READ_LATENCY-1:0]  r_pipe_port;    // read return pipeline: port id

    // ------------------------------------------------------------------------
    // Combinational request / grant signals
    // ------------------------------------------------------------------------
    logic w_req0;
    logic w_req1;
    logic w_grant0;
    logic w_grant1;
    logic w_acc_any;
    logic w_acc_read;
    logic w_acc_lock;

    assign w_req0 = s0_chipselect & (s0_read | s0_write);
    assign w_req1 = s1_chipselect & (s1_read | s1_write);

    // Grant selection: a lock restricts the grant to its owner; otherwise a
    // lone requester wins and a tie goes to the port that did not go last.
    // Nothing is granted while reset is held, so both ports see waitrequest.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_LOCKED0: w_grant0 = w_req0;
                ST_LOCKED1: w_grant1 = w_req1;
                default: begin
                    if (w_req0 && w_req1) begin
                        w_grant0 = r_rr_last;
                        w_grant1 = ~r_rr_last;
                    end else begin
                        w_grant0 = w_req0;
                        w_grant1 = w_req1;
                    end
                end
            endcase
        end
    end

    // A grant already implies a request, so a grant is an accept.
    assign w_acc_any  = w_grant0 | w_grant1;

    // Read with write asserted on the same port is a write: no return.
    assign w_acc_read = (w_grant0 & s0_read & ~s0_write) |
                        (w_grant1 & s1_read & ~s1_write);

    assign w_acc_lock = (w_grant0 & s0_lock) | (w_grant1 & s1_lock);

    // ------------------------------------------------------------------------
    // Port handshake outputs
    // ------------------------------------------------------------------------
    assign s0_waitrequest = ~w_grant0;
    assign s1_waitrequest = ~w_grant1;

    // Memory read data is shared; readdatavalid tells each port whose it is.
    assign s0_readdata = mem_readdata;
    assign s1_readdata = mem_readdata;

    assign s0_readdatavalid = r_pipe_valid[READ_LATENCY-1] & ~r_pipe_port[READ_LATENCY-1];
    assign s1_readdatavalid = r_pipe_valid[READ_LATENCY-1] &  r_pipe_port[READ_LATENCY-1];

    assign lock_timeout = r_lock_timeout;

    // ------------------------------------------------------------------------
    // Memory-side mux (address/data only meaningful with chipselect high)
    // ------------------------------------------------------------------------
    assign mem_chipselect = w_acc_any;
    assign mem_write      = (w_grant0 & s0_write) | (w_grant1 & s1_write);
    assign mem_address    = w_grant1 ? s1_address    : s0_address;
    assign mem_byteenable = w_grant1 ? s1_byteenable : s0_byteenable;
    assign mem_writedata  = w_grant1 ? s1_writedata  : s0_writedata;
    assign mem_clken      = 1'b1;

    // ------------------------------------------------------------------------
    // Read return pipeline, one stage per cycle of memory read latency
    // ------------------------------------------------------------------------
    generate
        if (READ_LATENCY == 1) begin : g_pipe_single
            // Single stage: capture the accepted read directly.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pipe_valid <= '0;
                    r_pipe_port  <= '0;
                end else begin
                    r_pipe_valid <= w_acc_read;
                    r_pipe_port  <= w_grant1;
                end
            end
        end else begin : g_pipe_multi
            // Multi stage: shift the accepted read towards the output end.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pipe_valid <= '0;
                    r_pipe_port  <= '0;
                end else begin
                    r_pipe_valid <= {r_pipe_valid[READ_LATENCY-2:0], w_acc_read};
                    r_pipe_port  <= {r_pipe_port[READ_LATENCY-2:0],  w_grant1};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Lock state machine with round-robin history and idle watchdog
    // ------------------------------------------------------------------------
    // Tracks lock ownership, last-accepted port, and releases a stale lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_rr_last      <= 1'b1;
            r_idle_cnt     <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_lock_timeout <= 1'b0;

            if (w_acc_any) begin
                r_rr_last <= w_grant1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_acc_any && w_acc_lock) begin
                        r_state <= w_grant1 ? ST_LOCKED1 : ST_LOCKED0;
                    end
                end

                ST_LOCKED0, ST_LOCKED1: begin
                    // Only the owner can be granted here, so any accept is
                    // an owner accept.
                    if (w_acc_any) begin
                        r_idle_cnt <= '0;
                        if (!w_acc_lock) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (r_idle_cnt == c_cnt_last) begin
                        r_idle_cnt     <= '0;
                        r_state        <= ST_IDLE;
                        r_lock_timeout <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + c_cnt_w'(1);
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_idle_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_arbiter
//  Purpose  : Directed self-checking bench for data_memory_arbiter with a
//             behavioural 1-cycle-latency byte-enabled memory attached.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_memory_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic              clk;
    logic              reset;
    logic              s0_chipselect, s0_read, s0_write, s0_lock;
    logic [ADDR_W-1:0] s0_address;
    logic [BE_W-1:0]   s0_byteenable;
    logic [DATA_W-1:0] s0_writedata;
    logic              s0_waitrequest;
    logic [DATA_W-1:0] s0_readdata;
    logic              s0_readdatavalid;
    logic              s1_chipselect, s1_read, s1_write, s1_lock;
    logic [ADDR_W-1:0] s1_address;
    logic [BE_W-1:0]   s1_byteenable;
    logic [DATA_W-1:0] s1_writedata;
    logic              s1_waitrequest;
    logic [DATA_W-1:0] s1_readdata;
    logic              s1_readdatavalid;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              lock_timeout;

    int checks = 0;
    int errors = 0;

    data_memory_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BE_W        (BE_W),
        .READ_LATENCY(1),
        .LOCK_TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s0_chipselect   (s0_chipselect),
        .s0_read         (s0_read),
        .s0_write        (s0_write),
        .s0_lock         (s0_lock),
        .s0_address      (s0_address),
        .s0_byteenable   (s0_byteenable),
        .s0_writedata    (s0_writedata),
        .s0_waitrequest  (s0_waitrequest),
        .s0_readdata     (s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_chipselect   (s1_chipselect),
        .s1_read         (s1_read),
        .s1_write        (s1_write),
        .s1_lock         (s1_lock),
        .s1_address      (s1_address),
        .s1_byteenable   (s1_byteenable),
        .s1_writedata    (s1_writedata),
        .s1_waitrequest  (s1_waitrequest),
        .s1_readdata     (s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata),
        .lock_timeout    (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory: registered read, byte-lane writes.
    logic [DATA_W-1:0] mem [1024];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        s0_chipselect = 0; s0_read = 0; s0_write = 0; s0_lock = 0;
        s0_address = '0; s0_byteenable = 4'hF; s0_writedata = '0;
    endtask

    task automatic idle1();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_lock = 0;
        s1_address = '0; s1_byteenable = 4'hF; s1_writedata = '0;
    endtask

    task automatic rd0(input logic [9:0] a, input logic lk);
        s0_chipselect = 1; s0_read = 1; s0_write = 0; s0_lock = lk; s0_address = a;
    endtask

    task automatic rd1(input logic [9:0] a, input logic lk);
        s1_chipselect = 1; s1_read = 1; s1_write = 0; s1_lock = lk; s1_address = a;
    endtask

    task automatic wr0(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        s0_chipselect = 1; s0_read = 0; s0_write = 1; s0_lock = 0;
        s0_address = a; s0_byteenable = be; s0_writedata = d;
    endtask

    task automatic wr1(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d, input logic lk);
        s1_chipselect = 1; s1_read = 0; s1_write = 1; s1_lock = lk;
        s1_address = a; s1_byteenable = be; s1_writedata = d;
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b1;
        idle0(); idle1();
        rd0(10'h001, 1'b0);   // a request during reset must still wait
        #2;
        chk("rst_s0_wait", 32'(s0_waitrequest), 32'd1);
        chk("rst_s1_wait", 32'(s1_waitrequest), 32'd1);
        chk("rst_mem_cs",  32'(mem_chipselect), 32'd0);
        chk("rst_mem_wr",  32'(mem_write),      32'd0);
        chk("rst_clken",   32'(mem_clken),      32'd1);
        chk("rst_lockto",  32'(lock_timeout),   32'd0);
        chk("rst_rdv0",    32'(s0_readdatavalid), 32'd0);
        chk("rst_rdv1",    32'(s1_readdatavalid), 32'd0);
        idle0();
        cyc(); cyc();
        reset = 1'b0;

        // ---------------- write then read, port 0 ----------------
        wr0(10'h005, 4'hF, 32'hDEADBEEF);
        #1;
        chk("t1_wr_wait0", 32'(s0_waitrequest), 32'd0);
        chk("t1_wr_cs",    32'(mem_chipselect), 32'd1);
        chk("t1_wr_we",    32'(mem_write),      32'd1);
        chk("t1_wr_addr",  32'(mem_address),    32'h005);
        cyc();
        rd0(10'h005, 1'b0);
        #1;
        chk("t1_rd_wait0", 32'(s0_waitrequest), 32'd0);
        chk("t1_rd_we",    32'(mem_write),      32'd0);
        cyc();
        idle0();
        #1;
        chk("t1_rdv0",  32'(s0_readdatavalid), 32'd1);
        chk("t1_data",  s0_readdata,            32'hDEADBEEF);
        chk("t1_rdv1",  32'(s1_readdatavalid), 32'd0);
        chk("t1_cs_idle", 32'(mem_chipselect), 32'd0);
        cyc();
        chk("t1_rdv0_end", 32'(s0_readdatavalid), 32'd0);

        // ---------------- partial byte-enable write ----------------
        wr0(10'h007, 4'hF, 32'hAAAAAAAA);
        cyc();
        wr0(10'h007, 4'h3, 32'h11223344);
        #1;
        chk("t5_be", 32'(mem_byteenable), 32'h3);
        cyc();
        rd0(10'h007, 1'b0);
        cyc();
        idle0();
        #1;
        chk("t5_rdv0", 32'(s0_readdatavalid), 32'd1);
        chk("t5_data", s0_readdata,            32'hAAAA3344);
        cyc();

        // ---------------- preload for later reads ----------------
        wr0(10'h010, 4'hF, 32'h10101010);
        cyc();
        idle0();
        wr1(10'h020, 4'hF, 32'h20202020, 1'b0);
        #1;
        chk("pre_wait1", 32'(s1_waitrequest), 32'd0);
        cyc();
        rd1(10'h020, 1'b0);
        cyc();
        idle1();
        #1;
        chk("pre_rdv1", 32'(s1_readdatavalid), 32'd1);
        chk("pre_rdv0", 32'(s0_readdatavalid), 32'd0);
        chk("pre_data1", s1_readdata,           32'h20202020);
        cyc();

        // ---------------- reset with a read in flight ----------------
        rd0(10'h005, 1'b0);
        cyc();                 // read accepted at this edge
        idle0();
        reset = 1'b1;
        #1;
        chk("t6_rdv0_drop", 32'(s0_readdatavalid), 32'd0);
        cyc();
        chk("t6_rdv0_hold", 32'(s0_readdatavalid), 32'd0);
        chk("t6_rdv1_hold", 32'(s1_readdatavalid), 32'd0);
        reset = 1'b0;

        // ---------------- alternating reads on contention ----------------
        rd0(10'h010, 1'b0);
        rd1(10'h020, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t2_wait0_%0d", k), 32'(s0_waitrequest), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("t2_wait1_%0d", k), 32'(s1_waitrequest), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk($sformatf("t2_rdv0_%0d", k), 32'(s0_readdatavalid), (k % 2 == 1) ? 32'd1 : 32'd0);
                chk($sformatf("t2_rdv1_%0d", k), 32'(s1_readdatavalid), (k % 2 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("t2_data_%0d", k), s0_readdata, (k % 2 == 1) ? 32'h10101010 : 32'h20202020);
            end
            cyc();
        end
        idle0(); idle1();
        #1;
        chk("t2_rdv0_last", 32'(s0_readdatavalid), 32'd1);
        chk("t2_rdv1_last", 32'(s1_readdatavalid), 32'd0);
        chk("t2_data_last", s0_readdata,            32'h10101010);
        cyc();

        // ---------------- port 1 lock, port 0 requesting throughout ----------------
        rd1(10'h030, 1'b1);
        rd0(10'h010, 1'b0);
        #1;
        chk("t3_g0_wait1", 32'(s1_waitrequest), 32'd0);
        chk("t3_g0_wait0", 32'(s0_waitrequest), 32'd1);
        cyc();
        idle1();
        #1;
        chk("t3_g1_wait0", 32'(s0_waitrequest), 32'd1);
        chk("t3_g1_rdv1",  32'(s1_readdatavalid), 32'd1);
        cyc();
        #1;
        chk("t3_g2_wait0", 32'(s0_waitrequest), 32'd1);
        wr1(10'h030, 4'hF, 32'h33333333, 1'b0);
        #1;
        chk("t3_g3_wait1", 32'(s1_waitrequest), 32'd0);
        chk("t3_g3_wait0", 32'(s0_waitrequest), 32'd1);
        chk("t3_g3_we",    32'(mem_write),      32'd1);
        cyc();
        idle1();
        #1;
        chk("t3_g4_wait0", 32'(s0_waitrequest), 32'd0);
        cyc();
        idle0();
        #1;
        chk("t3_g5_rdv0", 32'(s0_readdatavalid), 32'd1);
        chk("t3_g5_data", s0_readdata,            32'h10101010);
        cyc();

        // ---------------- port 0 lock, idle until timeout ----------------
        rd0(10'h010, 1'b1);
        #1;
        chk("t4_h0_wait0", 32'(s0_waitrequest), 32'd0);
        cyc();
        idle0();
        rd1(10'h020, 1'b0);
        for (int h = 1; h <= 4; h++) begin
            #1;
            chk($sformatf("t4_h%0d_wait1", h), 32'(s1_waitrequest), 32'd1);
            chk($sformatf("t4_h%0d_lockto", h), 32'(lock_timeout), 32'd0);
            cyc();
        end
        #1;
        chk("t4_h5_lockto", 32'(lock_timeout),   32'd1);
        chk("t4_h5_wait1",  32'(s1_waitrequest), 32'd0);
        cyc();
        idle1();
        #1;
        chk("t4_h6_lockto", 32'(lock_timeout),     32'd0);
        chk("t4_h6_rdv1",   32'(s1_readdatavalid), 32'd1);
        chk("t4_h6_data",   s1_readdata,           32'h20202020);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
